// File: rtl/pipeline_stage_elastic.sv
// Elastic valid/ready pipeline stage with a DEPTH-entry circular buffer.
// in_ready comes only from registered occupancy, so back-pressure never forms a
// combinational path from out_ready to in_ready. An entry can be stored as a
// no-op (nullify), and the whole stage can be flushed.
module pipeline_stage_elastic #(
  parameter int WIDTH = 64,
  parameter int CTRL_WIDTH = 16,
  parameter int DEPTH = 2,
  parameter logic [CTRL_WIDTH-1:0] NULL_CTRL = '0,
  parameter bit CLEAR_PAYLOAD = 1'b1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             nullify,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PL_W  = WIDTH - CTRL_WIDTH;
  localparam logic [WIDTH-1:0] NULL_ENTRY = {{PL_W{1'b0}}, NULL_CTRL};
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;
  logic [PL_W-1:0]  store_payload;
  logic [WIDTH-1:0] store_entry;

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (count_q < CNT_FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  // An empty stage shows the no-op entry rather than whatever the slot last held.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : NULL_ENTRY;

  // Handshakes; flush suppresses both so nothing moves in a flush cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Form the entry to store: nullify replaces control and optionally clears payload.
  always_comb begin
    store_payload = in_data[WIDTH-1:CTRL_WIDTH];
    if (nullify && CLEAR_PAYLOAD) store_payload = '0;
    store_entry = {store_payload, nullify ? NULL_CTRL : in_data[CTRL_WIDTH-1:0]};
  end

  // Next-state for buffer, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = store_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset loads every slot with the no-op entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NULL_ENTRY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: five configurations share one upstream and
// downstream; each is tracked by a queue model and checked after every edge.
module tb_pipeline_stage_elastic;

  typedef logic [63:0] q_t [$];

  logic clk = 1'b0;
  logic reset, in_valid, nullify, flush, out_ready;
  logic [63:0] in_data;

  logic ir_d2, ov_d2; logic [63:0] od_d2; logic [1:0] cnt_d2;
  logic ir_nc, ov_nc; logic [63:0] od_nc; logic [1:0] cnt_nc;
  logic ir_d4, ov_d4; logic [63:0] od_d4; logic [2:0] cnt_d4;
  logic ir_d3, ov_d3; logic [63:0] od_d3; logic [1:0] cnt_d3;
  logic ir_d1, ov_d1; logic [63:0] od_d1; logic [0:0] cnt_d1;

  int ncmp = 0;
  int nfail = 0;
  q_t q_d2, q_nc, q_d4, q_d3, q_d1;
  q_t got4, got3;
  int got1;
  int idx;
  bit acc;

  // free-running clock
  always #5 clk = ~clk;

  pipeline_stage_elastic #(.WIDTH(64), .CTRL_WIDTH(16), .DEPTH(2), .NULL_CTRL(16'h0000), .CLEAR_PAYLOAD(1'b1)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d2), .in_data(in_data), .nullify(nullify),
    .flush(flush), .out_valid(ov_d2), .out_ready(out_ready), .out_data(od_d2), .count(cnt_d2));
  pipeline_stage_elastic #(.WIDTH(64), .CTRL_WIDTH(16), .DEPTH(2), .NULL_CTRL(16'h0000), .CLEAR_PAYLOAD(1'b0)) u_nc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_nc), .in_data(in_data), .nullify(nullify),
    .flush(flush), .out_valid(ov_nc), .out_ready(out_ready), .out_data(od_nc), .count(cnt_nc));
  pipeline_stage_elastic #(.WIDTH(64), .CTRL_WIDTH(16), .DEPTH(4), .NULL_CTRL(16'h5A5A), .CLEAR_PAYLOAD(1'b1)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d4), .in_data(in_data), .nullify(nullify),
    .flush(flush), .out_valid(ov_d4), .out_ready(out_ready), .out_data(od_d4), .count(cnt_d4));
  pipeline_stage_elastic #(.WIDTH(64), .CTRL_WIDTH(16), .DEPTH(3), .NULL_CTRL(16'h00C3), .CLEAR_PAYLOAD(1'b0)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d3), .in_data(in_data), .nullify(nullify),
    .flush(flush), .out_valid(ov_d3), .out_ready(out_ready), .out_data(od_d3), .count(cnt_d3));
  pipeline_stage_elastic #(.WIDTH(64), .CTRL_WIDTH(16), .DEPTH(1), .NULL_CTRL(16'h0011), .CLEAR_PAYLOAD(1'b1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d1), .in_data(in_data), .nullify(nullify),
    .flush(flush), .out_valid(ov_d1), .out_ready(out_ready), .out_data(od_d1), .count(cnt_d1));

  task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Queue model of one edge: a FIFO of at most depth entries.
  function automatic void mstep(ref q_t q, input int depth, input logic [15:0] nc, input bit clr);
    bit do_push, do_pop;
    logic [63:0] e;
    do_push = in_valid && (q.size() < depth) && !flush;
    do_pop  = (q.size() != 0) && out_ready && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e = in_data;
        if (nullify) begin
          e[15:0] = nc;
          if (clr) e[63:16] = '0;
        end
        q.push_back(e);
      end
    end
  endfunction

  task automatic chk(input string tag, input q_t q, input int depth, input logic [15:0] nc,
                     input logic ov, input logic ir, input logic [63:0] od, input logic [31:0] cnt);
    logic [63:0] eod;
    eod = (q.size() != 0) ? q[0] : {48'h0, nc};
    cmp({tag, ".out_valid"}, 64'(ov), 64'(q.size() != 0));
    cmp({tag, ".in_ready"}, 64'(ir), 64'(q.size() < depth));
    cmp({tag, ".count"}, 64'(cnt), 64'(q.size()));
    cmp({tag, ".out_data"}, od, eod);
  endtask

  task automatic check_all();
    chk("d2", q_d2, 2, 16'h0000, ov_d2, ir_d2, od_d2, 32'(cnt_d2));
    chk("nc", q_nc, 2, 16'h0000, ov_nc, ir_nc, od_nc, 32'(cnt_nc));
    chk("d4", q_d4, 4, 16'h5A5A, ov_d4, ir_d4, od_d4, 32'(cnt_d4));
    chk("d3", q_d3, 3, 16'h00C3, ov_d3, ir_d3, od_d3, 32'(cnt_d3));
    chk("d1", q_d1, 1, 16'h0011, ov_d1, ir_d1, od_d1, 32'(cnt_d1));
  endtask

  task automatic clear_models();
    q_d2.delete(); q_nc.delete(); q_d4.delete(); q_d3.delete(); q_d1.delete();
  endtask

  // One clock: log deliveries seen before the edge, advance models, check after.
  task automatic step();
    if (!reset && out_ready && !flush) begin
      if (ov_d4) got4.push_back(od_d4);
      if (ov_d3) got3.push_back(od_d3);
      if (ov_d1) got1++;
    end
    if (reset) begin
      clear_models();
    end else begin
      mstep(q_d2, 2, 16'h0000, 1'b1);
      mstep(q_nc, 2, 16'h0000, 1'b0);
      mstep(q_d4, 4, 16'h5A5A, 1'b1);
      mstep(q_d3, 3, 16'h00C3, 1'b0);
      mstep(q_d1, 1, 16'h0011, 1'b1);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; nullify = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    check_all();
    cmp("rst.in_ready", 64'(ir_d2), 64'd1);
    cmp("rst.out_data_d4", od_d4, 64'h5A5A);
    repeat (2) step();
    reset = 1'b0;

    // first push right after reset release, then fill DEPTH=2
    in_valid = 1'b1; in_data = 64'h1111_0000_0000_0042;
    step();
    cmp("first_push.ov", 64'(ov_d2), 64'd1);
    in_data = 64'h1111_0000_0000_0043;
    step();
    cmp("fill.cnt_d2", 64'(cnt_d2), 64'd2);

    // asynchronous reset between edges
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    clear_models();
    check_all();
    cmp("midrst.ov", 64'(ov_d2), 64'd0);
    cmp("midrst.cnt", 64'(cnt_d2), 64'd0);
    cmp("midrst.od", od_d2, 64'd0);
    cmp("midrst.ir", 64'(ir_d2), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // back-pressure fill and drain on DEPTH=4
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 64'hA1 + 64'(k);
      step();
    end
    cmp("bp.cnt", 64'(cnt_d4), 64'd4);
    cmp("bp.ir", 64'(ir_d4), 64'd0);
    in_data = 64'hA5;
    step();
    cmp("bp.held_cnt", 64'(cnt_d4), 64'd4);
    got4.delete();
    out_ready = 1'b1;
    idx = 4;
    for (int t = 0; t < 20 && got4.size() < 6; t++) begin
      in_valid = (idx < 6);
      in_data = 64'hA1 + 64'(idx);
      acc = in_valid && ir_d4;
      step();
      if (acc) idx++;
    end
    cmp("bp.delivered", 64'(got4.size()), 64'd6);
    for (int k = 0; k < got4.size(); k++) cmp("bp.order", got4[k], 64'hA1 + 64'(k));
    in_valid = 1'b0;
    repeat (5) step();

    // streaming across pointer wrap on DEPTH=3
    got3.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 64'h100 + 64'(k);
      step();
      cmp("stream.cnt_d3", 64'(cnt_d3), 64'd1);
    end
    in_valid = 1'b0;
    step();
    cmp("stream.delivered", 64'(got3.size()), 64'd10);
    for (int k = 0; k < got3.size(); k++) cmp("stream.order", got3[k], 64'h100 + 64'(k));
    repeat (4) step();

    // DEPTH=1 throughput: one entry per two cycles
    got1 = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cmp("d1.in_ready", 64'(ir_d1), 64'((k % 2) == 0));
      in_data = 64'h200 + 64'(k);
      step();
    end
    cmp("d1.delivered", 64'(got1), 64'd4);
    in_valid = 1'b0;
    repeat (3) step();

    // nullify with and without payload clearing
    out_ready = 1'b0; in_valid = 1'b1; nullify = 1'b1; in_data = 64'hDEAD_BEEF_0000_1234;
    step();
    cmp("null.clr_od", od_d2, 64'd0);
    cmp("null.clr_ov", 64'(ov_d2), 64'd1);
    cmp("null.keep_od", od_nc, 64'hDEAD_BEEF_0000_0000);
    cmp("null.keep_ov", 64'(ov_nc), 64'd1);
    nullify = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    // flush colliding with push and pop
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'hB1; step();
    in_data = 64'hB2; step();
    cmp("flush.pre_cnt_d4", 64'(cnt_d4), 64'd2);
    in_data = 64'hB3; out_ready = 1'b1; flush = 1'b1;
    step();
    cmp("flush.cnt_d2", 64'(cnt_d2), 64'd0);
    cmp("flush.ov_d4", 64'(ov_d4), 64'd0);
    cmp("flush.cnt_d4", 64'(cnt_d4), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    got4.delete();
    repeat (3) step();
    cmp("flush.no_b3", 64'(got4.size()), 64'd0);

    // randomized traffic with an asynchronous reset in the middle
    for (int t = 0; t < 400; t++) begin
      if (t == 200) begin
        #2 reset = 1'b1;
        #1;
        clear_models();
        check_all();
        step();
        reset = 1'b0;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      nullify   = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_elastic.md
# pipeline_stage_elastic

Parametrised successor to the single-register pipeline stage: an elastic, valid/ready pipeline stage with a DEPTH-entry buffer that absorbs downstream back-pressure without a combinational ready path. It supports per-entry nullify (control field forced to a no-op encoding) and whole-stage flush. It sits between any two pipeline stages, such as decode→execute, and replaces the stall/bubble register where back-pressure must be decoupled.

## Interface
Parameters:
- WIDTH, 64: total entry width in bits; must be > CTRL_WIDTH.
- CTRL_WIDTH, 16: control field width; the field occupies bits [CTRL_WIDTH-1:0] of each entry.
- DEPTH, 2: buffer entries; must be ≥ 1; any value, not limited to powers of two.
- NULL_CTRL, '0: CTRL_WIDTH-bit no-op control encoding, used on reset, on nullify, and when the buffer is empty.
- CLEAR_PAYLOAD, 1: 1 = a nullified entry's payload bits [WIDTH-1:CTRL_WIDTH] are zeroed; 0 = payload passes through unchanged.

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept; equals (count < DEPTH); driven from registered state only.
- in_data  in  WIDTH  upstream entry.
- nullify  in  1  the entry accepted this cycle is stored in nullified form.
- flush  in  1  discards all buffered entries and any push in the same cycle.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  downstream accepts the head.
- out_data  out  WIDTH  head entry; {0, NULL_CTRL} when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is a circular buffer with rd_ptr, wr_ptr (0..DEPTH-1) and a count. Pointers wrap from DEPTH-1 to 0.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- On push, mem[wr_ptr] receives the stored entry and wr_ptr advances:
  - If nullify=0, the stored entry is in_data.
  - If nullify=1, the control field becomes NULL_CTRL. The payload becomes 0 if CLEAR_PAYLOAD, otherwise in_data payload.
- On pop, rd_ptr advances.
- Count update: count += push − pop. push & pop together leaves count unchanged.
- When full, in_ready=0 even if out_ready=1. There is no same-cycle bypass into a full buffer, so in_ready never depends on out_ready.
- Nullified entries still occupy a slot and are delivered with out_valid=1, as a pipeline bubble carrying no-op control.
- nullify is ignored when no push occurs.
- Flush: the next state is count=0 and rd_ptr=wr_ptr=0. All other inputs are ignored that cycle. Memory contents are left unchanged but are unobservable.
- Empty output: out_data = {(WIDTH-CTRL_WIDTH)'0, NULL_CTRL}, never stale mem contents.
- Reset (async, at any time, including mid-transfer): count=0, pointers=0, every mem entry = {0, NULL_CTRL}.
  - Outputs immediately become in_ready=1 (DEPTH≥1), out_valid=0, out_data={0,NULL_CTRL}, count=0.

## Timing
- Latency: an entry pushed at edge N appears on out_data with out_valid=1 after edge N (visible in cycle N+1). There is no combinational in→out path.
- Throughput: 1 entry/cycle sustained for DEPTH ≥ 2.
  - DEPTH=1 sustains at most 1 entry per 2 cycles when out_ready is held high, because a full single entry blocks the push.
- out_data, out_valid, in_ready and count are functions of registered state only.
- Handshake: upstream must hold in_data stable while in_valid & ~in_ready. The stage holds out_data stable while out_valid & ~out_ready, unless flush or reset occurs.
- Simultaneous flush + push + pop: flush wins; next count=0.
- Reset deassertion: the first push is accepted on the first edge after reset falls.

## Test plan
- Reset mid-stream: DEPTH=2 holding 2 entries, assert reset between edges. Required: out_valid=0, count=0, out_data=NULL_CTRL immediately; in_ready=1.
- Back-pressure fill/drain: DEPTH=4, push 0xA1..0xA6 with out_ready=0.
  - Required: accept 0xA1..0xA4, count=4, in_ready=0.
  - Then raise out_ready: outputs appear in order 0xA1..0xA6 with no loss or duplication.
- Streaming with wrap: DEPTH=3, in_valid=out_ready=1 for 10 cycles with incrementing data. Required: 1 entry per cycle, count stable at 1, order preserved across pointer wrap.
- Nullify: CTRL_WIDTH=16, NULL_CTRL=16'h0000, in_data=64'hDEAD_BEEF_0000_1234 with nullify=1.
  - CLEAR_PAYLOAD=1: output is 0.
  - CLEAR_PAYLOAD=0: output is 64'hDEAD_BEEF_0000_0000; out_valid=1 in both cases.
- Flush collision: count=2 with push and pop in the same cycle as flush. Required: next cycle count=0, out_valid=0, and the pushed entry never appears.
- DEPTH=1 throughput: in_valid=out_ready=1 for 8 cycles. Required: exactly 4 entries delivered; in_ready alternates 1/0.
